// File: rtl/fsm_sched_pkg.sv
// fsm_sched_pkg: shared state encoding, default sizes and round-robin pick helper
package fsm_sched_pkg;
  localparam int DEF_NREQ = 2;
  localparam int DEF_W = 8;
  typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_e;
  // winner = first set bit searching upward from last+1, modulo n (n <= 8)
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] last, input int n);
    logic [2:0] w;
    int k;
    w = last;
    for (int i = n; i >= 1; i--) begin
      k = (int'(last) + i) % n;
      if (req[k[2:0]]) w = k[2:0];
    end
    return w;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over NREQ requests
//   req   - request levels
//   last  - index granted most recently
//   gnt   - one-hot winner (meaningful only when req is nonzero)
//   idx   - winner index
module rr_arbiter import fsm_sched_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  assign idx = IW'(rr_pick(8'(req), 3'(last), NREQ));
  assign gnt = NREQ'(1) << idx;
endmodule

// File: rtl/fsm_stream_sched.sv
// fsm_stream_sched: round-robin sharing of one bit-serial FSM among NREQ word clients
//   clk, rst_n          - clock, async active-low reset
//   req, word_in        - request levels and per-requester W-bit words
//   gnt, done, result   - one-hot grant, one-cycle completion pulse, collected FSM output word
//   busy                - high outside IDLE
//   fsm_clr/valid/inp   - serial FSM clear, bit strobe and data
//   fsm_out             - serial FSM output, FSM_LAT clocks behind fsm_inp
module fsm_stream_sched import fsm_sched_pkg::*; #(
  parameter int NREQ = DEF_NREQ,
  parameter int W = DEF_W,
  parameter int FSM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] word_in,
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] done,
  output logic [W-1:0]    result,
  output logic            busy,
  output logic            fsm_clr,
  output logic            fsm_valid,
  output logic            fsm_inp,
  input  logic            fsm_out
);
  localparam int CW = $clog2(W + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = (FSM_LAT > 0) ? FSM_LAT : 1;
  state_e state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, arb_gnt;
  logic [IW-1:0] last_q, last_d, arb_idx;
  logic [W-1:0] sh_q, sh_d, res_q, res_d;
  logic [CW-1:0] bit_q, bit_d, cap_q, cap_d;
  logic [LW-1:0] vld_q, vld_d;
  logic cap_v;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (.req(req), .last(last_q), .gnt(arb_gnt), .idx(arb_idx));
  assign gnt = gnt_q;
  assign result = res_q;
  assign busy = state_q != IDLE;
  assign fsm_clr = state_q == CLR;
  assign fsm_valid = state_q == SHIFT;
  assign fsm_inp = fsm_valid & sh_q[0];
  assign done = (state_q == DONE) ? gnt_q : '0;
  // capture strobe is fsm_valid delayed by the FSM latency
  assign vld_d = LW'({vld_q, fsm_valid});
  assign cap_v = (FSM_LAT == 0) ? fsm_valid : vld_q[LW-1];
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    sh_d = sh_q;
    res_d = cap_v ? (res_q | (W'(fsm_out) << cap_q)) : res_q;
    bit_d = bit_q;
    cap_d = cap_v ? cap_q + CW'(1) : cap_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = CLR;
        gnt_d = arb_gnt;
        last_d = arb_idx;
        sh_d = word_in[int'(arb_idx)*W +: W];
      end
      CLR: begin
        state_d = SHIFT;
        bit_d = '0;
        cap_d = '0;
        res_d = '0;
      end
      SHIFT: begin
        sh_d = sh_q >> 1;
        bit_d = bit_q + CW'(1);
        if (bit_q == CW'(W - 1)) state_d = (FSM_LAT > 0) ? DRAIN : DONE;
      end
      DRAIN: if (cap_d == CW'(W)) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        gnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      last_q <= IW'(NREQ - 1);
      sh_q <= '0;
      res_q <= '0;
      bit_q <= '0;
      cap_q <= '0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      sh_q <= sh_d;
      res_q <= res_d;
      bit_q <= bit_d;
      cap_q <= cap_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: tb/tb_fsm_stream_sched.sv
// tb_fsm_stream_sched: directed vector bench for fsm_stream_sched (identity and inverting FSM stubs)
module tb_fsm_stream_sched;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic [1:0] req_a = 0, gnt_a, done_a;
  logic [7:0] w0_a = 0, w1_a = 0, result_a;
  logic busy_a, clr_a, valid_a, inp_a, fout_a;
  logic [0:0] req_b = 0, gnt_b, done_b;
  logic [7:0] w_b = 0, result_b;
  logic busy_b, clr_b, valid_b, inp_b, fout_b;
  int n_chk = 0, n_fail = 0;
  fsm_stream_sched #(.NREQ(2), .W(8), .FSM_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .word_in({w1_a, w0_a}), .gnt(gnt_a), .done(done_a),
    .result(result_a), .busy(busy_a), .fsm_clr(clr_a), .fsm_valid(valid_a), .fsm_inp(inp_a), .fsm_out(fout_a));
  fsm_stream_sched #(.NREQ(1), .W(8), .FSM_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .word_in(w_b), .gnt(gnt_b), .done(done_b),
    .result(result_b), .busy(busy_b), .fsm_clr(clr_b), .fsm_valid(valid_b), .fsm_inp(inp_b), .fsm_out(fout_b));
  always_ff @(posedge clk or negedge rst_n) fout_a <= !rst_n ? 1'b0 : inp_a;
  assign fout_b = ~inp_b;
  typedef struct {logic [1:0] req; logic [7:0] w0, w1; logic [1:0] eg; logic [7:0] er;} vec_t;
  vec_t tbl[8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // runs one transaction on dut_a from wherever it stands (IDLE or just granted) to the done cycle
  task automatic txn_a(input logic [1:0] eg, input logic [7:0] er, output int gw);
    int c, nb, nclr, bad;
    logic [7:0] bits;
    c = 0;
    while (gnt_a == 2'b00 && c < 30) begin
      @(negedge clk);
      c++;
    end
    gw = c;
    chk("gnt", gnt_a, eg);
    c = 0; nb = 0; nclr = 0; bad = 0; bits = 0;
    while (done_a == 2'b00 && c < 40) begin
      if (valid_a && nb < 8) begin
        bits[nb] = inp_a;
        nb++;
      end
      nclr += int'(clr_a);
      if (gnt_a != eg || !busy_a) bad++;
      @(negedge clk);
      c++;
    end
    chk("done_latency", c, 10);
    chk("done", done_a, eg);
    chk("result", result_a, er);
    chk("stream_bits", bits, er);
    chk("stream_len", nb, 8);
    chk("clr_pulses", nclr, 1);
    chk("gnt_held", bad, 0);
  endtask
  task automatic idle_a(input logic [7:0] er);
    @(negedge clk);
    chk("idle_gnt", gnt_a, 0);
    chk("idle_busy", busy_a, 0);
    chk("idle_done", done_a, 0);
    chk("result_hold", result_a, er);
  endtask
  initial begin
    int gw, c, vc, bad;
    tbl[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 8'hA5};
    tbl[1] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};
    tbl[2] = '{2'b11, 8'h11, 8'h22, 2'b01, 8'h11};
    tbl[3] = '{2'b11, 8'h11, 8'h22, 2'b10, 8'h22};
    tbl[4] = '{2'b10, 8'h00, 8'h5A, 2'b10, 8'h5A};
    tbl[5] = '{2'b10, 8'h00, 8'h0F, 2'b10, 8'h0F};
    tbl[6] = '{2'b01, 8'hFF, 8'h00, 2'b01, 8'hFF};
    tbl[7] = '{2'b01, 8'h00, 8'h00, 2'b01, 8'h00};
    #1;
    chk("rst_gnt", gnt_a, 0);
    chk("rst_outs", {done_a, result_a, busy_a, clr_a, valid_a, inp_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    // inverting Mealy stub, no drain stage
    req_b = 1'b1; w_b = 8'h3C;
    @(negedge clk);
    req_b = 1'b0;
    chk("b_gnt", gnt_b, 1);
    c = 0;
    while (done_b == 1'b0 && c < 30) begin
      @(negedge clk);
      c++;
    end
    chk("b_done_latency", c, 9);
    chk("b_result", result_b, 8'hC3);
    @(negedge clk);
    chk("b_idle", {gnt_b, busy_b, done_b}, 0);
    // table: back-to-back transactions with requests changed at each done
    req_a = tbl[0].req; w0_a = tbl[0].w0; w1_a = tbl[0].w1;
    for (int i = 0; i < 8; i++) begin
      txn_a(tbl[i].eg, tbl[i].er, gw);
      chk("grant_wait", gw, 1);
      if (i < 7) begin
        req_a = tbl[i+1].req; w0_a = tbl[i+1].w0; w1_a = tbl[i+1].w1;
      end else req_a = 0;
      idle_a(tbl[i].er);
    end
    // one-cycle request pulse still completes, then no regrant
    req_a = 2'b01; w0_a = 8'h96;
    @(negedge clk);
    req_a = 2'b00; w0_a = 8'h00;
    txn_a(2'b01, 8'h96, gw);
    idle_a(8'h96);
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (gnt_a != 0 || busy_a) bad++;
    end
    chk("no_regrant", bad, 0);
    // requester 1 arrives mid-transaction; must wait for the full turnaround
    req_a = 2'b01; w0_a = 8'h33;
    @(negedge clk);
    req_a = 2'b11; w1_a = 8'h44;
    txn_a(2'b01, 8'h33, gw);
    req_a = 2'b10;
    idle_a(8'h33);
    txn_a(2'b10, 8'h44, gw);
    chk("late_grant_wait", gw, 1);
    req_a = 2'b00;
    idle_a(8'h44);
    // reset during the 4th stream bit
    req_a = 2'b01; w0_a = 8'hA5;
    vc = 0; c = 0;
    while (vc < 4 && c < 30) begin
      @(negedge clk);
      c++;
      if (valid_a) vc++;
    end
    chk("reached_shift4", vc, 4);
    rst_n = 0;
    #1;
    chk("midrst_outs", {gnt_a, done_a, result_a, busy_a, clr_a, valid_a, inp_a}, 0);
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_a != 0 || busy_a) bad++;
    end
    chk("midrst_quiet", bad, 0);
    req_a = 2'b11; w0_a = 8'h77; w1_a = 8'h88;
    rst_n = 1;
    txn_a(2'b01, 8'h77, gw);
    chk("post_rst_wait", gw, 1);
    req_a = 2'b00;
    idle_a(8'h77);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
